// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dumpState_t;

endpackage

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks an index over every register with a valid/ready handshake.
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  dumpStart,
  input  logic                  dumpReady,
  output logic                  dumpValid,
  output logic [ADDR_WIDTH-1:0] dumpAddr,
  output logic                  dumpBusy,
  output logic                  dumpDone
);

  localparam int unsigned IDX_WIDTH = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  // One extra index bit keeps the last-beat compare free of wrap-around.
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

  dumpState_t           state;
  dumpState_t           stateNext;
  logic [IDX_WIDTH-1:0] index;
  logic [IDX_WIDTH-1:0] indexNext;

  // State and index registers, cleared asynchronously so a reset aborts a dump.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= stateNext;
      index <= indexNext;
    end
  end

  // Next-state and index update; a beat advances only when accepted.
  always_comb begin
    stateNext = state;
    indexNext = index;
    case (state)
      IDLE: begin
        if (dumpStart) begin
          stateNext = DUMP;
          indexNext = '0;
        end
      end
      DUMP: begin
        if (dumpReady) begin
          if (index == LAST_IDX) begin
            stateNext = DONE;
          end else begin
            indexNext = index + IDX_WIDTH'(1);
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
        indexNext = '0;
      end
      default: begin
        stateNext = IDLE;
        indexNext = '0;
      end
    endcase
  end

  assign dumpValid = (state == DUMP);
  assign dumpBusy  = (state != IDLE);
  assign dumpDone  = (state == DONE);
  assign dumpAddr  = index[ADDR_WIDTH-1:0];

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports, one write port, dump port.
module param_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b0,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeFile,
  input  logic                  regWrite,
  input  logic                  dumpStart,
  input  logic                  dumpReady,
  output logic                  dumpValid,
  output logic [ADDR_WIDTH-1:0] dumpAddr,
  output logic [DATA_WIDTH-1:0] dumpData,
  output logic                  dumpBusy,
  output logic                  dumpDone
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  writeEn;

  // Writes to the hardwired-zero register are dropped.
  assign writeEn = regWrite && !(ZERO_REG && (writeReg == '0));

  // Storage array with asynchronous clear.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[writeReg] <= writeFile;
    end
  end

  // Read port 1: array value, then bypass, then zero-register override.
  always_comb begin
    readData1 = regs[readReg1];
    if (BYPASS && regWrite && (readReg1 == writeReg)) begin
      readData1 = writeFile;
    end
    if (ZERO_REG && (readReg1 == '0)) begin
      readData1 = '0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    readData2 = regs[readReg2];
    if (BYPASS && regWrite && (readReg2 == writeReg)) begin
      readData2 = writeFile;
    end
    if (ZERO_REG && (readReg2 == '0)) begin
      readData2 = '0;
    end
  end

  // Dump data shows current contents; bypass never applies, so a same-edge write is not seen.
  always_comb begin
    dumpData = regs[dumpAddr];
    if (ZERO_REG && (dumpAddr == '0)) begin
      dumpData = '0;
    end
  end

  regfile_dump_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dumpSeq (
    .clock    (clock),
    .resetN   (resetN),
    .dumpStart(dumpStart),
    .dumpReady(dumpReady),
    .dumpValid(dumpValid),
    .dumpAddr (dumpAddr),
    .dumpBusy (dumpBusy),
    .dumpDone (dumpDone)
  );

endmodule

// File: tb/tb_param_register_file.sv
// Bench: a narrow zero-reg/bypass instance and a wide plain instance driven in lockstep.
module tb_param_register_file;

  logic        clock = 1'b0;
  logic        resetN;
  logic [3:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeFile;
  logic        regWrite;

  logic        dumpStartA, dumpReadyA, dumpValidA, dumpBusyA, dumpDoneA;
  logic [2:0]  dumpAddrA;
  logic [15:0] rd1A, rd2A, dumpDataA;

  logic        dumpStartB, dumpReadyB, dumpValidB, dumpBusyB, dumpDoneB;
  logic [3:0]  dumpAddrB;
  logic [31:0] rd1B, rd2B, dumpDataB;

  int          checks;
  int          errors;

  logic [15:0] modelA [8];
  logic [31:0] modelB [16];

  logic        pw;
  logic [3:0]  pa;
  logic [31:0] pd;

  always #5 clock = ~clock;

  param_register_file #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dutA (
    .clock(clock), .resetN(resetN),
    .readReg1(readReg1[2:0]), .readReg2(readReg2[2:0]),
    .readData1(rd1A), .readData2(rd2A),
    .writeReg(writeReg[2:0]), .writeFile(writeFile[15:0]), .regWrite(regWrite),
    .dumpStart(dumpStartA), .dumpReady(dumpReadyA), .dumpValid(dumpValidA),
    .dumpAddr(dumpAddrA), .dumpData(dumpDataA), .dumpBusy(dumpBusyA), .dumpDone(dumpDoneA)
  );

  param_register_file #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dutB (
    .clock(clock), .resetN(resetN),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1B), .readData2(rd2B),
    .writeReg(writeReg), .writeFile(writeFile), .regWrite(regWrite),
    .dumpStart(dumpStartB), .dumpReady(dumpReadyB), .dumpValid(dumpValidB),
    .dumpAddr(dumpAddrB), .dumpData(dumpDataB), .dumpBusy(dumpBusyB), .dumpDone(dumpDoneB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 8; i++) modelA[i] = 16'h0;
    for (int i = 0; i < 16; i++) modelB[i] = 32'h0;
  endtask

  task automatic modelWrite(input logic [3:0] a, input logic [31:0] d);
    if (a[2:0] != 3'd0) modelA[a[2:0]] = d[15:0];
    modelB[a] = d;
  endtask

  // Narrow instance: reg 0 is zero, a read of the address being written sees writeFile.
  function automatic logic [15:0] expReadA(input logic [3:0] r);
    if (r[2:0] == 3'd0) return 16'h0;
    if (regWrite && (writeReg[2:0] == r[2:0])) return writeFile[15:0];
    return modelA[r[2:0]];
  endfunction

  function automatic logic [15:0] expDumpA(input int i);
    if (i == 0) return 16'h0;
    return modelA[3'(i)];
  endfunction

  task automatic checkReads();
    chk("rd1A", 64'(rd1A), 64'(expReadA(readReg1)));
    chk("rd2A", 64'(rd2A), 64'(expReadA(readReg2)));
    chk("rd1B", 64'(rd1B), 64'(modelB[readReg1]));
    chk("rd2B", 64'(rd2B), 64'(modelB[readReg2]));
  endtask

  task automatic doWrite(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    regWrite = 1'b1; writeReg = a; writeFile = d;
    @(negedge clock);
    regWrite = 1'b0;
    modelWrite(a, d);
  endtask

  // Run both dumps together. randomMode: random ready and writes; otherwise ready toggles 1/0
  // with directed writes. abortAt3 asserts reset while narrow beat 3 is presented.
  task automatic runDump(input bit randomMode, input bit abortAt3);
    int idxA, idxB, phA, phB, cyc;
    bit lpw;
    logic [3:0] lpa;
    logic [31:0] lpd;
    idxA = 0; idxB = 0; phA = 0; phB = 0; lpw = 1'b0; lpa = '0; lpd = '0;
    @(negedge clock);
    regWrite = 1'b0; dumpStartA = 1'b1; dumpStartB = 1'b1;
    for (cyc = 0; cyc < 400 && (phA < 3 || phB < 3); cyc++) begin
      @(negedge clock);
      if (lpw) modelWrite(lpa, lpd);
      lpw = 1'b0;
      dumpStartA = (cyc == 3);
      dumpStartB = (cyc == 3);
      if (randomMode) begin
        dumpReadyA = 1'($urandom_range(0, 1));
        dumpReadyB = 1'($urandom_range(0, 1));
        regWrite   = 1'($urandom_range(0, 1));
        writeReg   = 4'($urandom);
        writeFile  = $urandom;
      end else begin
        dumpReadyA = (cyc % 2 == 0);
        dumpReadyB = (cyc % 2 == 0);
        regWrite   = (phA == 0) && ((idxA == 2) || (idxA == 5 && dumpReadyA));
        writeReg   = (idxA == 2) ? 4'd6 : 4'd5;
        writeFile  = (idxA == 2) ? 32'h0BAD : 32'h1234;
      end
      readReg1 = 4'($urandom);
      readReg2 = ($urandom_range(0, 2) == 0) ? writeReg : 4'($urandom);
      if (regWrite) begin lpw = 1'b1; lpa = writeReg; lpd = writeFile; end
      #1;
      checkReads();
      case (phA)
        0: begin
          chk("dumpValidA", 64'(dumpValidA), 64'(1));
          chk("dumpBusyA", 64'(dumpBusyA), 64'(1));
          chk("dumpDoneA", 64'(dumpDoneA), 64'(0));
          chk("dumpAddrA", 64'(dumpAddrA), 64'(idxA));
          chk("dumpDataA", 64'(dumpDataA), 64'(expDumpA(idxA)));
        end
        1: begin
          chk("doneA", 64'(dumpDoneA), 64'(1));
          chk("doneValidA", 64'(dumpValidA), 64'(0));
          chk("doneBusyA", 64'(dumpBusyA), 64'(1));
        end
        2: begin
          chk("donePulseA", 64'(dumpDoneA), 64'(0));
          chk("idleBusyA", 64'(dumpBusyA), 64'(0));
        end
        default: chk("stayIdleA", 64'(dumpBusyA), 64'(0));
      endcase
      case (phB)
        0: begin
          chk("dumpValidB", 64'(dumpValidB), 64'(1));
          chk("dumpDoneB", 64'(dumpDoneB), 64'(0));
          chk("dumpAddrB", 64'(dumpAddrB), 64'(idxB));
          chk("dumpDataB", 64'(dumpDataB), 64'(modelB[4'(idxB)]));
        end
        1: begin
          chk("doneB", 64'(dumpDoneB), 64'(1));
          chk("doneValidB", 64'(dumpValidB), 64'(0));
        end
        2: begin
          chk("donePulseB", 64'(dumpDoneB), 64'(0));
          chk("idleBusyB", 64'(dumpBusyB), 64'(0));
        end
        default: chk("stayIdleB", 64'(dumpBusyB), 64'(0));
      endcase
      if (abortAt3 && phA == 0 && idxA == 3) begin
        #2 resetN = 1'b0;
        #1;
        chk("abortValidA", 64'(dumpValidA), 64'(0));
        chk("abortBusyA", 64'(dumpBusyA), 64'(0));
        chk("abortDoneA", 64'(dumpDoneA), 64'(0));
        chk("abortAddrA", 64'(dumpAddrA), 64'(0));
        chk("abortValidB", 64'(dumpValidB), 64'(0));
        chk("abortBusyB", 64'(dumpBusyB), 64'(0));
        chk("abortDataB", 64'(dumpDataB), 64'(0));
        regWrite = 1'b0; dumpStartA = 1'b0; dumpStartB = 1'b0;
        modelClear();
        @(negedge clock);
        resetN = 1'b1;
        return;
      end
      if (phA == 0) begin
        if (dumpReadyA) begin
          if (idxA == 7) phA = 1; else idxA++;
        end
      end else if (phA < 3) phA++;
      if (phB == 0) begin
        if (dumpReadyB) begin
          if (idxB == 15) phB = 1; else idxB++;
        end
      end else if (phB < 3) phB++;
    end
    chk("dumpBudgetA", 64'(phA), 64'(3));
    chk("dumpBudgetB", 64'(phB), 64'(3));
    @(negedge clock);
    if (lpw) modelWrite(lpa, lpd);
    regWrite = 1'b0; dumpStartA = 1'b0; dumpStartB = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; pw = 1'b0; pa = '0; pd = '0;
    resetN = 1'b0; regWrite = 1'b0; writeReg = '0; writeFile = '0;
    readReg1 = '0; readReg2 = '0;
    dumpStartA = 1'b0; dumpReadyA = 1'b0; dumpStartB = 1'b0; dumpReadyB = 1'b0;
    modelClear();

    // Reset state.
    #12;
    chk("rstValidA", 64'(dumpValidA), 64'(0));
    chk("rstBusyA", 64'(dumpBusyA), 64'(0));
    chk("rstDoneA", 64'(dumpDoneA), 64'(0));
    chk("rstAddrB", 64'(dumpAddrB), 64'(0));
    chk("rstDataB", 64'(dumpDataB), 64'(0));
    chk("rstBusyB", 64'(dumpBusyB), 64'(0));
    @(negedge clock);
    resetN = 1'b1;

    // Basic write then read.
    doWrite(4'd4, 32'd17);
    @(negedge clock);
    readReg1 = 4'd4; readReg2 = 4'd3;
    #1;
    chk("wr4A", 64'(rd1A), 64'(17));
    chk("rd3A", 64'(rd2A), 64'(0));
    chk("wr4B", 64'(rd1B), 64'(17));
    checkReads();

    // Bypass on the narrow instance, old value on the wide one.
    doWrite(4'd5, 32'd9);
    @(negedge clock);
    regWrite = 1'b1; writeReg = 4'd5; writeFile = 32'h00AA; readReg1 = 4'd5; readReg2 = 4'd4;
    #1;
    chk("bypassA", 64'(rd1A), 64'(16'h00AA));
    chk("noBypassB", 64'(rd1B), 64'(9));
    @(negedge clock);
    regWrite = 1'b0;
    modelWrite(4'd5, 32'h00AA);
    #1;
    chk("afterEdgeB", 64'(rd1B), 64'(32'h00AA));

    // Zero register, including a same-cycle write to it.
    doWrite(4'd0, 32'hFFFF);
    @(negedge clock);
    readReg1 = 4'd0;
    #1;
    chk("zeroRegA", 64'(rd1A), 64'(0));
    chk("noZeroRegB", 64'(rd1B), 64'(32'hFFFF));
    @(negedge clock);
    regWrite = 1'b1; writeReg = 4'd0; writeFile = 32'h5555;
    #1;
    chk("zeroBypassA", 64'(rd1A), 64'(0));
    @(negedge clock);
    regWrite = 1'b0;
    modelWrite(4'd0, 32'h5555);

    // r = r*3 everywhere, wide top register gets a marker.
    for (int r = 0; r < 16; r++) doWrite(4'(r), 32'(r * 3));
    doWrite(4'd15, 32'hDEADBEEF);
    @(negedge clock);
    readReg1 = 4'd15; readReg2 = 4'd7;
    #1;
    chk("deadbeefB", 64'(rd1B), 64'(32'hDEADBEEF));
    chk("reg7A", 64'(rd2A), 64'(16'hBEEF));

    // Directed dump with toggling ready, then one aborted by reset, then a random one.
    runDump(1'b0, 1'b0);
    runDump(1'b0, 1'b1);
    for (int r = 0; r < 16; r++) begin
      readReg1 = 4'(r); readReg2 = 4'(15 - r);
      #1;
      checkReads();
    end
    repeat (3) begin
      @(negedge clock);
      chk("noDoneAfterAbortA", 64'(dumpDoneA), 64'(0));
      chk("noDoneAfterAbortB", 64'(dumpDoneB), 64'(0));
    end
    runDump(1'b1, 1'b0);

    // Random read/write traffic.
    repeat (200) begin
      @(negedge clock);
      if (pw) modelWrite(pa, pd);
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 4'($urandom);
      writeFile = $urandom;
      readReg1  = ($urandom_range(0, 2) == 0) ? writeReg : 4'($urandom);
      readReg2  = 4'($urandom);
      pw = regWrite; pa = writeReg; pd = writeFile;
      #1;
      checkReads();
    end
    @(negedge clock);
    regWrite = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised general-purpose register file for the datapath, succeeding the fixed 8×16 register file. Provides two combinational read ports and one clocked write port. Adds configurable width and depth, an optional hardwired-zero register, optional write-to-read bypass, and asynchronous clear. A sequential dump port walks every register out over a valid/ready handshake, so benches and debug logic read state without hierarchical probing.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per register
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH registers
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 0, 1 = a read of the address being written this cycle returns writeFile

Ports:
- clock  in  1  single clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- readReg1  in  ADDR_WIDTH  read port 1 address
- readReg2  in  ADDR_WIDTH  read port 2 address
- readData1  out  DATA_WIDTH  read port 1 data, combinational
- readData2  out  DATA_WIDTH  read port 2 data, combinational
- writeReg  in  ADDR_WIDTH  write address
- writeFile  in  DATA_WIDTH  write data
- regWrite  in  1  write enable
- dumpStart  in  1  request a full dump, sampled in IDLE only
- dumpReady  in  1  consumer accepts current dump beat
- dumpValid  out  1  dumpAddr/dumpData valid
- dumpAddr  out  ADDR_WIDTH  index of current dump beat
- dumpData  out  DATA_WIDTH  contents of register dumpAddr
- dumpBusy  out  1  dump in progress
- dumpDone  out  1  one-cycle pulse after last beat accepted

## Operation
- Write: at rising clock, if regWrite, register[writeReg] <= writeFile. With ZERO_REG=1 and writeReg=0, write dropped.
- Read: readDataN = register[readRegN]. With ZERO_REG=1 and readRegN=0, output 0. With BYPASS=1, regWrite=1, readRegN==writeReg (and not the zero register): output writeFile. With BYPASS=0: old value until the edge.
- Dump FSM, states IDLE, DUMP, DONE:
  - IDLE: dumpStart=1 -> DUMP, index <= 0.
  - DUMP: dumpValid=1, dumpAddr=index, dumpData=register[index] (zero-reg rule applies, bypass does not). On dumpValid&&dumpReady: index < DEPTH-1 -> index+1; index == DEPTH-1 -> DONE. No acceptance: hold index and state.
  - DONE: dumpDone=1 for one cycle -> IDLE.
- dumpBusy=1 in DUMP and DONE. dumpStart ignored outside IDLE.
- Writes during a dump proceed normally. dumpData reflects current contents, so a register written before its beat is dumped with the new value.
- Index counter is ADDR_WIDTH+1 bits or compared explicitly; no wrap-around to 0 inside a dump.

## Timing
- Reset (resetN=0, asynchronous): all registers 0, FSM IDLE, index 0, dumpValid/dumpBusy/dumpDone 0, dumpAddr 0, dumpData = register[0] = 0. Reset mid-dump aborts without dumpDone.
- Write latency: 1 edge. Read latency: combinational, 0 cycles.
- Dump: first beat valid the cycle after dumpStart is sampled. Minimum DEPTH beats plus 1 DONE cycle with dumpReady tied high. dumpDone asserts the cycle after the last acceptance.
- dumpAddr/dumpData stable while dumpValid && !dumpReady.
- Simultaneous regWrite to register k and dump beat k accepted: beat carries the pre-edge value.

## Structure
- Shared package regfile_pkg: FSM state enum (IDLE, DUMP, DONE) and default parameter constants (DATA_WIDTH, ADDR_WIDTH).
- Sub-module regfile_dump_seq: dump FSM and index counter. Outputs dumpAddr/dumpValid/dumpBusy/dumpDone. Top-level muxes dumpData from the array.
- Storage array, write logic and read/bypass muxing stay in param_register_file.

## Test plan
Default DATA_WIDTH=16, ADDR_WIDTH=3 unless noted.
- Reset/write/read: resetN pulse, then regWrite=1, writeReg=4, writeFile=17, 1 edge; readReg1=4 -> readData1=17. readReg2=3 -> 0.
- Bypass: BYPASS=1, reg 5 = 9. Same cycle: regWrite=1, writeReg=5, writeFile=0x00AA, readReg1=5 -> readData1=0x00AA before the edge. BYPASS=0 instance -> 9.
- Zero register: ZERO_REG=1, write 0xFFFF to reg 0 -> readData1=0. Dump beat 0 data = 0.
- Dump with backpressure: regs r=r*3, dumpStart 1 cycle, dumpReady toggling 1/0 -> 8 beats, addr 0..7, data 0,3,...,21, each held while stalled. dumpDone single pulse. dumpStart during busy ignored.
- Reset mid-dump: assert resetN=0 at beat 3 -> dumpValid/dumpBusy 0 immediately, all registers 0, no dumpDone. New dumpStart restarts at addr 0.
- Wide config: DATA_WIDTH=32, ADDR_WIDTH=4. Write 0xDEADBEEF to reg 15. Full dump yields 16 beats, last = 0xDEADBEEF.
